eth_tx_mux: RTL and testbench

ETH_TX_MUX -- requirements
Module: eth_tx_mux

---
 rtl/eth_tx_mux.sv | 195 +++++++++++++++++++
 tb/tb_eth_tx_mux.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_mux.sv
// Ethernet transmit multiplexer: selects one of SOURCE_NUM byte sources and
// frames it with preamble/SFD, minimum-size padding, error marking and IFG.
module eth_tx_mux #(
  parameter int SOURCE_NUM = 4,
  parameter int IFG_LEN    = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SOURCE_NUM-1:0]   sel,
  output logic                    stop,
  output logic                    wr_allow,
  input  logic [8*SOURCE_NUM-1:0] src_data,
  input  logic [SOURCE_NUM-1:0]   src_valid,
  input  logic [SOURCE_NUM-1:0]   src_last,
  output logic [SOURCE_NUM-1:0]   src_rd,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  output logic                    tx_er
);

  localparam int CW = $clog2(SOURCE_NUM);

  localparam logic [10:0] MIN_LEN = 11'd60;
  localparam logic [10:0] MAX_LEN = 11'd1514;
  localparam logic [10:0] CNT_MAX = 11'h7FF;
  localparam logic [7:0]  IFG_END = 8'(IFG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAD,
    DRAIN,
    IFG,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cur, cur_n;
  logic [10:0]   cnt, cnt_n;
  logic [2:0]    pre_cnt, pre_n;
  logic [7:0]    ifg_cnt, ifg_n;
  logic [7:0]    txd_n;
  logic          txen_n;
  logic          txer_n;
  logic          stop_n;
  logic          rd_hit;

  logic [CW-1:0] low_idx;
  logic [7:0]    cur_data;
  logic          cur_valid;
  logic          cur_last;
  logic [10:0]   cnt_inc;

  assign wr_allow  = (state == IDLE) & ~start;
  assign cur_valid = src_valid[cur];
  assign cur_last  = src_last[cur];
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 11'd1;

  // Lowest set index of sel (descending scan, last hit wins).
  always_comb begin
    low_idx = '0;
    for (int k = SOURCE_NUM - 1; k >= 0; k--) begin
      if (sel[k]) low_idx = CW'(k);
    end
  end

  // Byte lane of the current source.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < SOURCE_NUM; k++) begin
      if (cur == CW'(k)) cur_data = src_data[8*k +: 8];
    end
  end

  // Pop strobe; suppressed while rst is high so an abort pops nothing.
  always_comb begin
    src_rd = '0;
    if (rd_hit && !rst) src_rd[cur] = 1'b1;
  end

  // Next state plus next registered tx/stop values.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    pre_n   = pre_cnt;
    ifg_n   = ifg_cnt;
    txd_n   = 8'h00;
    txen_n  = 1'b0;
    txer_n  = 1'b0;
    stop_n  = 1'b0;
    rd_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (sel == '0) begin
            state_n = DONE;
            stop_n  = 1'b1;
          end else begin
            state_n = PRE;
            cur_n   = low_idx;
            cnt_n   = '0;
            pre_n   = '0;
            txd_n   = 8'h55;
            txen_n  = 1'b1;
          end
        end
      end
      PRE: begin
        txen_n = 1'b1;
        if (pre_cnt == 3'd6) begin
          txd_n   = 8'hD5;
          state_n = DATA;
        end else begin
          txd_n = 8'h55;
          pre_n = pre_cnt + 3'd1;
        end
      end
      DATA: begin
        ifg_n = '0;
        if (cur_valid) begin
          rd_hit = 1'b1;
          txd_n  = cur_data;
          txen_n = 1'b1;
          cnt_n  = cnt_inc;
          if (cur_last) begin
            state_n = (cnt_inc < MIN_LEN) ? PAD : IFG;
          end else if (cnt_inc == MAX_LEN) begin
            txer_n  = 1'b1;
            state_n = DRAIN;
          end
        end else begin
          txen_n  = 1'b1;
          txer_n  = 1'b1;
          state_n = IFG;
        end
      end
      PAD: begin
        txen_n = 1'b1;
        cnt_n  = cnt_inc;
        ifg_n  = '0;
        if (cnt_inc >= MIN_LEN) state_n = IFG;
      end
      DRAIN: begin
        ifg_n = '0;
        if (cur_valid) begin
          rd_hit = 1'b1;
          if (cur_last) state_n = IFG;
        end
      end
      IFG: begin
        if (ifg_cnt == IFG_END) begin
          stop_n  = 1'b1;
          state_n = IDLE;
        end else begin
          ifg_n = ifg_cnt + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      cnt     <= '0;
      pre_cnt <= '0;
      ifg_cnt <= '0;
      tx_data <= 8'h00;
      tx_en   <= 1'b0;
      tx_er   <= 1'b0;
      stop    <= 1'b0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      cnt     <= cnt_n;
      pre_cnt <= pre_n;
      ifg_cnt <= ifg_n;
      tx_data <= txd_n;
      tx_en   <= txen_n;
      tx_er   <= txer_n;
      stop    <= stop_n;
    end
  end

endmodule

// File: tb/tb_eth_tx_mux.sv
// Directed bench for eth_tx_mux: FWFT source models, per-cycle logging,
// hand-computed frame timing checks.
module tb_eth_tx_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sel;
  logic        stop;
  logic        wr_allow;
  logic [31:0] src_data;
  logic [3:0]  src_valid;
  logic [3:0]  src_last;
  logic [3:0]  src_rd;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_er;

  eth_tx_mux #(.SOURCE_NUM(4), .IFG_LEN(12)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .stop(stop), .wr_allow(wr_allow),
    .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_rd(src_rd),
    .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int len [4];
  int vlim[4];
  int pos [4];

  logic [7:0] d_log[0:2099];
  logic       e_log[0:2099];
  logic       x_log[0:2099];
  logic       w_log[0:2099];
  logic [3:0] r_log[0:2099];

  int n_en, n_er, er_cyc, stop_cyc, n_stop, rd_bad;
  int n_rd[4];

  function automatic logic [7:0] exp_byte(input int k, input int i);
    return 8'((i * 7 + k * 29 + 3) & 255);
  endfunction

  task automatic drive_src();
    for (int k = 0; k < 4; k++) begin
      src_valid[k] = (pos[k] < len[k]) && (pos[k] < vlim[k]);
      src_data[8*k +: 8] = exp_byte(k, pos[k]);
      src_last[k] = (pos[k] == len[k] - 1);
    end
  endtask

  task automatic src_clear();
    for (int k = 0; k < 4; k++) begin
      len[k] = 0; vlim[k] = 0; pos[k] = 0;
    end
    drive_src();
  endtask

  task automatic src_setup(input int k, input int l, input int v);
    len[k] = l; vlim[k] = v; pos[k] = 0;
    drive_src();
  endtask

  task automatic run_frame(input logic [3:0] s, input int src,
                           input int budget, input int inj, input int rc);
    logic [3:0] rdv;
    logic       fin;
    n_en = 0; n_er = 0; er_cyc = -1; stop_cyc = -1;
    n_stop = 0; rd_bad = 0; fin = 1'b0;
    for (int k = 0; k < 4; k++) n_rd[k] = 0;
    for (int i = 0; i < 2100; i++) begin
      d_log[i] = 8'hxx; e_log[i] = 1'b0; x_log[i] = 1'b0;
      w_log[i] = 1'b0; r_log[i] = 4'h0;
    end
    @(posedge clk); #1;
    start = 1'b1; sel = s;
    @(negedge clk);
    e_log[0] = tx_en; w_log[0] = wr_allow; r_log[0] = src_rd;
    @(posedge clk); #1;
    start = 1'b0; sel = 4'h0;
    for (int c = 1; c <= budget && !fin; c++) begin
      if (c == inj) begin start = 1'b1; sel = 4'b0001; end
      if (c == rc) rst = 1'b1;
      @(negedge clk);
      d_log[c] = tx_data; e_log[c] = tx_en; x_log[c] = tx_er;
      w_log[c] = wr_allow; r_log[c] = src_rd;
      if (tx_en) n_en++;
      if (tx_er) begin n_er++; if (er_cyc < 0) er_cyc = c; end
      if (stop) begin n_stop++; if (stop_cyc < 0) stop_cyc = c; fin = 1'b1; end
      rdv = src_rd;
      for (int k = 0; k < 4; k++) begin
        if (rdv[k]) begin
          n_rd[k]++;
          if (k != src) rd_bad++;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; sel = 4'h0; rst = 1'b0;
      for (int k = 0; k < 4; k++) if (rdv[k]) pos[k]++;
      drive_src();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({tx_en, tx_er, stop} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000", {tx_en, tx_er, stop});
    end
    n_chk++;
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h want 00", tx_data);
    end
    n_chk++;
    if (src_rd !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_rd got %b want 0000", src_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (wr_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wr_allow got %b want 1", wr_allow);
    end
  endtask

  task automatic test_frame64();
    int pbad, dbad;
    pbad = 0; dbad = 0;
    src_clear();
    src_setup(0, 64, 9999);
    run_frame(4'b0001, 0, 120, -1, -1);
    for (int c = 1; c <= 8; c++)
      if (d_log[c] !== ((c == 8) ? 8'hD5 : 8'h55) || e_log[c] !== 1'b1)
        pbad++;
    for (int i = 0; i < 64; i++)
      if (d_log[9+i] !== exp_byte(0, i) || e_log[9+i] !== 1'b1) dbad++;
    n_chk++;
    if (w_log[0] !== 1'b0 || e_log[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL f64_start_cyc wa=%b en=%b want 0 0", w_log[0], e_log[0]);
    end
    n_chk++;
    if (pbad !== 0) begin
      n_fail++;
      $display("FAIL f64_preamble bad=%0d want 0", pbad);
    end
    n_chk++;
    if (dbad !== 0) begin
      n_fail++;
      $display("FAIL f64_data bad=%0d want 0", dbad);
    end
    n_chk++;
    if (n_en !== 72 || n_er !== 0) begin
      n_fail++;
      $display("FAIL f64_en_cnt en=%0d er=%0d want 72 0", n_en, n_er);
    end
    n_chk++;
    if (stop_cyc !== 84) begin
      n_fail++;
      $display("FAIL f64_stop got %0d want 84", stop_cyc);
    end
    n_chk++;
    if (n_rd[0] !== 64 || rd_bad !== 0) begin
      n_fail++;
      $display("FAIL f64_rd got %0d bad=%0d want 64 0", n_rd[0], rd_bad);
    end
    n_chk++;
    if (w_log[5] !== 1'b0 || w_log[84] !== 1'b1) begin
      n_fail++;
      $display("FAIL f64_wr_allow mid=%b end=%b want 0 1", w_log[5], w_log[84]);
    end
  endtask

  task automatic test_pad();
    int dbad, pbad;
    dbad = 0; pbad = 0;
    src_clear();
    src_setup(0, 10, 9999);
    run_frame(4'b0001, 0, 120, -1, -1);
    for (int i = 0; i < 10; i++)
      if (d_log[9+i] !== exp_byte(0, i) || e_log[9+i] !== 1'b1) dbad++;
    for (int c = 19; c <= 68; c++)
      if (d_log[c] !== 8'h00 || e_log[c] !== 1'b1) pbad++;
    n_chk++;
    if (dbad !== 0 || pbad !== 0) begin
      n_fail++;
      $display("FAIL pad_bytes data_bad=%0d pad_bad=%0d want 0 0", dbad, pbad);
    end
    n_chk++;
    if (n_en !== 68 || e_log[69] !== 1'b0) begin
      n_fail++;
      $display("FAIL pad_len en=%0d want 68", n_en);
    end
    n_chk++;
    if (stop_cyc !== 80 || n_rd[0] !== 10) begin
      n_fail++;
      $display("FAIL pad_stop stop=%0d rd=%0d want 80 10", stop_cyc, n_rd[0]);
    end
  endtask

  task automatic test_underrun();
    int late;
    late = 0;
    src_clear();
    src_setup(0, 100, 20);
    run_frame(4'b0001, 0, 120, -1, -1);
    n_chk++;
    if (er_cyc !== 29 || n_er !== 1 || e_log[29] !== 1'b1) begin
      n_fail++;
      $display("FAIL urun_err cyc=%0d n=%0d en=%b want 29 1 1",
               er_cyc, n_er, e_log[29]);
    end
    n_chk++;
    if (d_log[29] !== 8'h00 || n_en !== 29) begin
      n_fail++;
      $display("FAIL urun_slot data=%h en=%0d want 00 29", d_log[29], n_en);
    end
    n_chk++;
    if (stop_cyc !== 41 || n_rd[0] !== 20) begin
      n_fail++;
      $display("FAIL urun_stop stop=%0d rd=%0d want 41 20", stop_cyc, n_rd[0]);
    end
    vlim[0] = 9999;
    drive_src();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (src_rd !== 4'h0) late++;
    end
    n_chk++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL urun_no_rd got %0d want 0", late);
    end
  endtask

  task automatic test_oversize();
    src_clear();
    src_setup(0, 1600, 9999);
    run_frame(4'b0001, 0, 1700, -1, -1);
    n_chk++;
    if (er_cyc !== 1522 || n_er !== 1) begin
      n_fail++;
      $display("FAIL ovs_err cyc=%0d n=%0d want 1522 1", er_cyc, n_er);
    end
    n_chk++;
    if (n_en !== 1522 || d_log[1522] !== exp_byte(0, 1513)) begin
      n_fail++;
      $display("FAIL ovs_en en=%0d data=%h want 1522 %h",
               n_en, d_log[1522], exp_byte(0, 1513));
    end
    n_chk++;
    if (n_rd[0] !== 1600 || stop_cyc !== 1620) begin
      n_fail++;
      $display("FAIL ovs_drain rd=%0d stop=%0d want 1600 1620",
               n_rd[0], stop_cyc);
    end
  endtask

  task automatic test_select();
    int dbad;
    dbad = 0;
    src_clear();
    src_setup(0, 64, 9999);
    src_setup(1, 64, 9999);
    src_setup(2, 64, 9999);
    run_frame(4'b0110, 1, 120, 20, -1);
    for (int i = 0; i < 64; i++)
      if (d_log[9+i] !== exp_byte(1, i)) dbad++;
    n_chk++;
    if (dbad !== 0) begin
      n_fail++;
      $display("FAIL sel_data bad=%0d want 0", dbad);
    end
    n_chk++;
    if (n_rd[1] !== 64 || n_rd[2] !== 0 || rd_bad !== 0) begin
      n_fail++;
      $display("FAIL sel_rd rd1=%0d rd2=%0d bad=%0d want 64 0 0",
               n_rd[1], n_rd[2], rd_bad);
    end
    n_chk++;
    if (stop_cyc !== 84 || n_stop !== 1) begin
      n_fail++;
      $display("FAIL sel_stop got %0d want 84", stop_cyc);
    end
  endtask

  task automatic test_empty_sel();
    src_clear();
    src_setup(0, 64, 9999);
    run_frame(4'b0000, 0, 10, -1, -1);
    n_chk++;
    if (stop_cyc !== 1) begin
      n_fail++;
      $display("FAIL empty_stop got %0d want 1", stop_cyc);
    end
    n_chk++;
    if (n_en !== 0 || e_log[0] !== 1'b0 || n_rd[0] !== 0) begin
      n_fail++;
      $display("FAIL empty_quiet en=%0d rd=%0d want 0 0", n_en, n_rd[0]);
    end
  endtask

  task automatic test_mid_reset();
    src_clear();
    src_setup(0, 64, 9999);
    run_frame(4'b0001, 0, 60, -1, 38);
    n_chk++;
    if (n_rd[0] !== 30 || r_log[38] !== 4'h0) begin
      n_fail++;
      $display("FAIL mrst_rd got %0d rd38=%b want 30 0000", n_rd[0], r_log[38]);
    end
    n_chk++;
    if (e_log[39] !== 1'b0 || x_log[39] !== 1'b0 || d_log[39] !== 8'h00) begin
      n_fail++;
      $display("FAIL mrst_out en=%b er=%b d=%h want 0 0 00",
               e_log[39], x_log[39], d_log[39]);
    end
    n_chk++;
    if (w_log[39] !== 1'b1 || stop_cyc !== -1) begin
      n_fail++;
      $display("FAIL mrst_idle wa=%b stop=%0d want 1 -1", w_log[39], stop_cyc);
    end
    src_clear();
    src_setup(0, 64, 9999);
    run_frame(4'b0001, 0, 120, -1, -1);
    n_chk++;
    if (stop_cyc !== 84 || n_rd[0] !== 64 || n_en !== 72) begin
      n_fail++;
      $display("FAIL mrst_restart stop=%0d rd=%0d en=%0d want 84 64 72",
               stop_cyc, n_rd[0], n_en);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sel = 4'h0;
    src_data = '0;
    src_valid = '0;
    src_last = '0;
    src_clear();
    test_reset();
    test_frame64();
    test_pad();
    test_underrun();
    test_oversize();
    test_select();
    test_empty_sel();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
